// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 memory responder.
// Holds the channel FSM state type, word width and wait limit.
package lc3_mem_pkg;

  localparam int WORD_W   = 16;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Fetch and data bus between the LC3 pipeline and its memory.
// master: pipeline side; slave: memory responder side.
interface lc3_mem_responder_if;
  import lc3_mem_pkg::*;

  logic              instrmem_rd;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] Instr_dout;
  logic              complete_instr;

  logic              Data_req;
  logic              Data_rd;
  logic [WORD_W-1:0] Data_addr;
  logic [WORD_W-1:0] Data_din;
  logic [WORD_W-1:0] Data_dout;
  logic              complete_data;

  modport master (
    output instrmem_rd, pc,
    output Data_req, Data_rd, Data_addr, Data_din,
    input  Instr_dout, complete_instr,
    input  Data_dout, complete_data
  );

  modport slave (
    input  instrmem_rd, pc,
    input  Data_req, Data_rd, Data_addr, Data_din,
    output Instr_dout, complete_instr,
    output Data_dout, complete_data
  );

endinterface

// File: rtl/lc3_mem_channel.sv
// One request channel: IDLE -> WAIT -> DONE FSM with wait counter.
// Ports: req/block in, payload capture, enter_done and done strobes.
module lc3_mem_channel
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int PW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          block,
  input  logic [PW-1:0] payload_in,
  output logic [PW-1:0] payload_cur,
  output logic [PW-1:0] payload,
  output logic          enter_done,
  output logic          done
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(WAIT_CYCLES);

  mem_state_e       state;
  mem_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             capture;

  assign capture = (state == IDLE) && req && !block;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (capture) begin
          cnt_nx   = CNT_INIT;
          state_nx = (CNT_INIT == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      payload <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        payload <= payload_in;
      end
    end
  end

  // With zero wait states DONE is entered on the capture edge,
  // so the live inputs stand in for the not-yet-captured payload.
  assign payload_cur = (state == IDLE) ? payload_in : payload;
  assign enter_done  = (state_nx == DONE);
  assign done        = (state == DONE);

endmodule

// File: rtl/lc3_mem_responder.sv
// LC3 memory responder: fetch and data channels over one word array.
// Ports: clk, reset (async, active-low), bus (slave), load_* preload.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int INSTR_WAIT = 0,
  parameter int DATA_WAIT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  lc3_mem_responder_if.slave bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DPW   = 1 + WORD_W + ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] i_cur;
  logic [ADDR_W-1:0] i_cap;
  logic              i_enter;
  logic              i_done;

  logic [DPW-1:0]    d_in;
  logic [DPW-1:0]    d_cur;
  logic [DPW-1:0]    d_cap;
  logic              d_enter;
  logic              d_done;

  logic              we;
  logic              d_we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;

  logic              c_instr;
  logic              c_data;
  logic [WORD_W-1:0] i_dout;
  logic [WORD_W-1:0] d_dout;

  lc3_mem_channel #(
    .WAIT_CYCLES (INSTR_WAIT),
    .PW          (ADDR_W)
  ) u_instr (
    .clk         (clk),
    .rst_n       (reset),
    .req         (bus.instrmem_rd),
    .block       (load_en),
    .payload_in  (bus.pc[ADDR_W-1:0]),
    .payload_cur (i_cur),
    .payload     (i_cap),
    .enter_done  (i_enter),
    .done        (i_done)
  );

  assign d_in = {bus.Data_rd, bus.Data_din,
                 bus.Data_addr[ADDR_W-1:0]};

  lc3_mem_channel #(
    .WAIT_CYCLES (DATA_WAIT),
    .PW          (DPW)
  ) u_data (
    .clk         (clk),
    .rst_n       (reset),
    .req         (bus.Data_req),
    .block       (load_en),
    .payload_in  (d_in),
    .payload_cur (d_cur),
    .payload     (d_cap),
    .enter_done  (d_enter),
    .done        (d_done)
  );

  // Writes commit on the edge entering DONE; preload wins a clash
  // and reset suppresses the write of an aborted transaction.
  assign d_we  = reset && d_enter && !d_cur[DPW-1];
  assign we    = load_en || d_we;
  assign waddr = load_en ? load_addr : d_cur[ADDR_W-1:0];
  assign wdata = load_en ? load_data : d_cur[ADDR_W +: WORD_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered reads sample the array before any same-edge write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_instr <= 1'b0;
      c_data  <= 1'b0;
      i_dout  <= '0;
      d_dout  <= '0;
    end else begin
      c_instr <= i_done;
      c_data  <= d_done;
      if (i_done) begin
        i_dout <= mem[i_cap];
      end
      if (d_done) begin
        d_dout <= mem[d_cap[ADDR_W-1:0]];
      end
    end
  end

  assign bus.complete_instr = c_instr;
  assign bus.complete_data  = c_data;
  assign bus.Instr_dout     = i_dout;
  assign bus.Data_dout      = d_dout;

  logic unused_ch;
  assign unused_ch = ^{i_cur, i_enter, d_cap[DPW-1:ADDR_W]};

  if (ADDR_W < WORD_W) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^{bus.pc[WORD_W-1:ADDR_W],
                         bus.Data_addr[WORD_W-1:ADDR_W]};
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder.
// Two instances: u0 (IW=0, DW=3) and u1 (IW=2, DW=0), shared preload.
module tb_lc3_mem_responder;

  localparam int K_LOAD  = 0;
  localparam int K_FETCH = 1;
  localparam int K_READ  = 2;
  localparam int K_WRITE = 3;
  localparam int NV      = 17;

  typedef struct {
    int          sel;
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  always #5 clk = ~clk;

  lc3_mem_responder_if bus0 ();
  lc3_mem_responder_if bus1 ();

  lc3_mem_responder #(
    .ADDR_W     (8),
    .INSTR_WAIT (0),
    .DATA_WAIT  (3)
  ) u0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  lc3_mem_responder #(
    .ADDR_W     (8),
    .INSTR_WAIT (2),
    .DATA_WAIT  (0)
  ) u1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vecs [NV];
  virtual lc3_mem_responder_if vb;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic xact(input int sel, input int kind,
                      input logic [15:0] addr,
                      input logic [15:0] data,
                      input logic [15:0] exp);
    int          n;
    int          w;
    logic        done;
    logic [15:0] dout;
    if (sel == 0) vb = bus0;
    else vb = bus1;
    if (sel == 0) w = (kind == K_FETCH) ? 0 : 3;
    else w = (kind == K_FETCH) ? 2 : 0;
    @(negedge clk);
    if (kind == K_LOAD) begin
      load_en   = 1'b1;
      load_addr = addr[7:0];
      load_data = data;
      @(negedge clk);
      load_en = 1'b0;
      return;
    end
    if (kind == K_FETCH) begin
      vb.instrmem_rd = 1'b1;
      vb.pc          = addr;
    end else begin
      vb.Data_req  = 1'b1;
      vb.Data_rd   = (kind == K_READ);
      vb.Data_addr = addr;
      vb.Data_din  = data;
    end
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      done = (kind == K_FETCH) ? vb.complete_instr
                               : vb.complete_data;
    end
    dout = (kind == K_FETCH) ? vb.Instr_dout : vb.Data_dout;
    vb.instrmem_rd = 1'b0;
    vb.Data_req    = 1'b0;
    chk($sformatf("latency u%0d k%0d @%h", sel, kind, addr),
        n, w + 2);
    if (kind != K_WRITE) begin
      chk($sformatf("data u%0d k%0d @%h", sel, kind, addr),
          dout, exp);
    end
    @(posedge clk);
    #1;
    done = (kind == K_FETCH) ? vb.complete_instr
                             : vb.complete_data;
    chk($sformatf("pulse_end u%0d k%0d @%h", sel, kind, addr),
        done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;

    vecs[0]  = '{0, K_LOAD,  16'h0000, 16'h1234, 16'h0000};
    vecs[1]  = '{0, K_FETCH, 16'h0000, 16'h0000, 16'h1234};
    vecs[2]  = '{0, K_WRITE, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[3]  = '{0, K_READ,  16'h0010, 16'h0000, 16'hBEEF};
    vecs[4]  = '{0, K_LOAD,  16'h0005, 16'h0ABC, 16'h0000};
    vecs[5]  = '{0, K_FETCH, 16'h0105, 16'h0000, 16'h0ABC};
    vecs[6]  = '{0, K_READ,  16'h0205, 16'h0000, 16'h0ABC};
    vecs[7]  = '{0, K_WRITE, 16'h01FF, 16'h5A5A, 16'h0000};
    vecs[8]  = '{0, K_READ,  16'h00FF, 16'h0000, 16'h5A5A};
    vecs[9]  = '{0, K_FETCH, 16'hFFFF, 16'h0000, 16'h5A5A};
    vecs[10] = '{0, K_LOAD,  16'h0020, 16'h1111, 16'h0000};
    vecs[11] = '{0, K_LOAD,  16'h0030, 16'h3333, 16'h0000};
    vecs[12] = '{0, K_LOAD,  16'h0041, 16'h4141, 16'h0000};
    vecs[13] = '{1, K_WRITE, 16'h0007, 16'h7777, 16'h0000};
    vecs[14] = '{1, K_READ,  16'h0107, 16'h0000, 16'h7777};
    vecs[15] = '{1, K_FETCH, 16'h0007, 16'h0000, 16'h7777};
    vecs[16] = '{1, K_FETCH, 16'h0000, 16'h0000, 16'h1234};

    reset     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    bus0.instrmem_rd = 1'b0;
    bus0.pc          = '0;
    bus0.Data_req    = 1'b0;
    bus0.Data_rd     = 1'b0;
    bus0.Data_addr   = '0;
    bus0.Data_din    = '0;
    bus1.instrmem_rd = 1'b0;
    bus1.pc          = '0;
    bus1.Data_req    = 1'b0;
    bus1.Data_rd     = 1'b0;
    bus1.Data_addr   = '0;
    bus1.Data_din    = '0;

    repeat (2) @(negedge clk);
    chk("rst complete_instr", bus0.complete_instr, 0);
    chk("rst complete_data", bus0.complete_data, 0);
    chk("rst Instr_dout", bus0.Instr_dout, 0);
    chk("rst Data_dout", bus0.Data_dout, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xact(vecs[i].sel, vecs[i].kind, vecs[i].addr,
           vecs[i].data, vecs[i].exp);
    end

    // Fetch reads 0x20 on the same edge the data write lands.
    @(negedge clk);
    bus0.Data_req  = 1'b1;
    bus0.Data_rd   = 1'b0;
    bus0.Data_addr = 16'h0020;
    bus0.Data_din  = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    bus0.instrmem_rd = 1'b1;
    bus0.pc          = 16'h0020;
    @(posedge clk);
    #1;
    chk("rbw early", bus0.complete_instr, 0);
    @(posedge clk);
    #1;
    chk("rbw pulse", bus0.complete_instr, 1);
    chk("rbw old value", bus0.Instr_dout, 16'h1111);
    bus0.instrmem_rd = 1'b0;
    @(posedge clk);
    #1;
    chk("rbw write pulse", bus0.complete_data, 1);
    bus0.Data_req = 1'b0;
    xact(0, K_READ, 16'h0020, 16'h0000, 16'h2222);

    // Preload collides with the data write's commit edge.
    @(negedge clk);
    bus0.Data_req  = 1'b1;
    bus0.Data_rd   = 1'b0;
    bus0.Data_addr = 16'h0050;
    bus0.Data_din  = 16'h5555;
    repeat (3) @(negedge clk);
    load_en   = 1'b1;
    load_addr = 8'h50;
    load_data = 16'h6666;
    @(negedge clk);
    load_en = 1'b0;
    @(posedge clk);
    #1;
    chk("collide pulse", bus0.complete_data, 1);
    bus0.Data_req = 1'b0;
    xact(0, K_READ, 16'h0050, 16'h0000, 16'h6666);

    // Preload held for 3 cycles blocks a pending fetch.
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 8'h40;
    load_data = 16'h4444;
    bus0.instrmem_rd = 1'b1;
    bus0.pc          = 16'h0041;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("load blocks fetch", bus0.complete_instr, 0);
    end
    @(negedge clk);
    load_en = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus0.complete_instr;
    end
    chk("post-load latency", n, 2);
    chk("post-load data", bus0.Instr_dout, 16'h4141);
    bus0.instrmem_rd = 1'b0;
    xact(0, K_READ, 16'h0040, 16'h0000, 16'h4444);

    // Reset during the WAIT of a write aborts it.
    @(negedge clk);
    bus0.Data_req  = 1'b1;
    bus0.Data_rd   = 1'b0;
    bus0.Data_addr = 16'h0030;
    bus0.Data_din  = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus0.Data_req = 1'b0;
    #1;
    chk("abort complete_instr", bus0.complete_instr, 0);
    chk("abort complete_data", bus0.complete_data, 0);
    chk("abort Instr_dout", bus0.Instr_dout, 0);
    chk("abort Data_dout", bus0.Data_dout, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | bus0.complete_data;
    end
    chk("abort no pulse", seen, 0);
    xact(0, K_READ, 16'h0030, 16'h0000, 16'h3333);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
